// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    // Opcode field values (instr[15:12])
    localparam logic [3:0]  HLT_OP    = 4'hF;
    localparam logic [3:0]  B_OP      = 4'hC;
    localparam logic [3:0]  BR_OP     = 4'hD;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Fetch sequencing: running normally, or parked on a fetched HLT
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_branch_target_calc.sv
// Redirect target selection: PC-relative B target, register-indirect BR
// target, or fall-through PC+2 when neither flavour is flagged.
module branch_target_calc
    import fetch_stage_pkg::*;
(
    input  logic [15:0] id_pc_plus2,
    input  logic [8:0]  branch_imm9,
    input  logic [15:0] br_reg_data,
    input  logic [15:0] pc_plus2,
    input  logic        is_b_instr,
    input  logic        is_br_instr,
    output logic [15:0] target
);

    logic [15:0] imm_sext;
    logic [15:0] b_target;

    // imm9 is a signed halfword offset: copy the sign bit upward
    assign imm_sext[8:0] = branch_imm9;
    generate
        for (genvar gi = 9; gi < 16; gi++) begin : g_sext
            assign imm_sext[gi] = branch_imm9[8];
        end
    endgenerate

    // Offset is in instruction units, so shift left once before adding
    assign b_target = id_pc_plus2 + {imm_sext[14:0], 1'b0};

    // B wins if decode ever flags both; default keeps sequential flow
    always_comb begin
        target = pc_plus2;
        if (is_b_instr) begin
            target = b_target;
        end else if (is_br_instr) begin
            target = br_reg_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALTED sequencer that parks on an HLT until a redirect or reset.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        BranchTaken,
    input  logic        is_b_instr,
    input  logic        is_br_instr,
    input  logic [8:0]  branch_imm9,
    input  logic [15:0] id_pc_plus2,
    input  logic [15:0] br_reg_data,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic [15:0]  instr_reg;
    logic [15:0]  pc_plus2_reg;
    logic         valid_reg;
    logic         halted_reg;

    logic [15:0]  pc_plus2;
    logic [15:0]  target;
    logic         redirect;
    logic         fetch_is_hlt;

    assign imem_addr    = pc_reg;
    assign pc_plus2     = pc_reg + 16'd2;
    // A stalled decode cannot have a trustworthy branch resolution
    assign redirect     = BranchTaken & ~stall;
    assign fetch_is_hlt = (imem_data[15:12] == HLT_OP);

    branch_target_calc u_target (
        .id_pc_plus2 (id_pc_plus2),
        .branch_imm9 (branch_imm9),
        .br_reg_data (br_reg_data),
        .pc_plus2    (pc_plus2),
        .is_b_instr  (is_b_instr),
        .is_br_instr (is_br_instr),
        .target      (target)
    );

    // Sequencer, PC and IF/ID register; redirect > stall > fetch/bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            pc_plus2_reg <= 16'h0000;
            valid_reg    <= 1'b0;
            halted_reg   <= 1'b0;
        end else if (redirect) begin
            // Also covers HALTED: an older branch resolved after the HLT
            // was fetched, so the HLT was on the wrong path
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
            pc_reg     <= target;
            instr_reg  <= NOP_INSTR;
            valid_reg  <= 1'b0;
        end else if (!stall) begin
            case (state_reg)
                ST_RUN: begin
                    instr_reg    <= imem_data;
                    pc_plus2_reg <= pc_plus2;
                    valid_reg    <= 1'b1;
                    if (fetch_is_hlt) begin
                        // Keep pc on the HLT so a flush-free halt is visible
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else begin
                        pc_reg <= pc_plus2;
                    end
                end
                ST_HALTED: begin
                    instr_reg <= NOP_INSTR;
                    valid_reg <= 1'b0;
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc             = pc_reg;
    assign if_id_instr    = instr_reg;
    assign if_id_pc_plus2 = pc_plus2_reg;
    assign if_id_valid    = valid_reg;
    assign halted         = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by randomized traffic against a
// behavioural fetch model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        BranchTaken;
    logic        is_b_instr;
    logic        is_br_instr;
    logic [8:0]  branch_imm9;
    logic [15:0] id_pc_plus2;
    logic [15:0] br_reg_data;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    // 256-halfword instruction memory, aliased across the address space
    logic [15:0] mem [0:255];

    int n_vec;
    int n_err;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    logic        m_valid;
    logic        m_halted;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .BranchTaken    (BranchTaken),
        .is_b_instr     (is_b_instr),
        .is_br_instr    (is_br_instr),
        .branch_imm9    (branch_imm9),
        .id_pc_plus2    (id_pc_plus2),
        .br_reg_data    (br_reg_data),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[8:1]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        BranchTaken = 1'b0;
        is_b_instr  = 1'b0;
        is_br_instr = 1'b0;
        branch_imm9 = 9'h000;
        id_pc_plus2 = 16'h0000;
        br_reg_data = 16'h0000;
    endtask

    // Redirect target straight from the rules: signed halfword offset
    function automatic logic [15:0] model_target();
        int off;
        off = (branch_imm9 >= 9'd256) ? int'(branch_imm9) - 512 : int'(branch_imm9);
        if (is_b_instr)  return 16'((int'(id_pc_plus2) + 2 * off) & 32'hFFFF);
        if (is_br_instr) return br_reg_data;
        return 16'((int'(m_pc) + 2) & 32'hFFFF);
    endfunction

    // One clock of the fetch model, evaluated on the current inputs
    task automatic model_step();
        logic [15:0] word;
        word = mem[m_pc[8:1]];
        if (BranchTaken && !stall) begin
            m_pc     = model_target();
            m_instr  = 16'h0000;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_pc2   = 16'((int'(m_pc) + 2) & 32'hFFFF);
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc     = m_pc2;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h1234;
        mem[1] = 16'h2345;
        mem[4] = 16'hF000;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_valid", 16'(if_id_valid), 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0000);
        $display("reset: pc=%h valid=%b halted=%b", pc, if_id_valid, halted);
        rst = 1'b0;

        // Sequential fetch
        tick();
        tick();
        chk("seq_instr", if_id_instr, 16'h2345);
        chk("seq_pc2", if_id_pc_plus2, 16'h0004);
        chk("seq_pc", pc, 16'h0004);
        $display("seq: pc=%h instr=%h pc2=%h", pc, if_id_instr, if_id_pc_plus2);

        // B redirect with negative offset
        BranchTaken = 1'b1; is_b_instr = 1'b1;
        id_pc_plus2 = 16'h0010; branch_imm9 = 9'h1FE;
        tick();
        chk("b_pc", pc, 16'h000C);
        chk("b_bubble", 16'(if_id_valid), 16'h0000);
        $display("b redirect: pc=%h valid=%b", pc, if_id_valid);
        idle_inputs();
        tick();
        chk("b_refill_valid", 16'(if_id_valid), 16'h0001);
        chk("b_refill_instr", if_id_instr, 16'h1006);
        $display("b refill: pc=%h instr=%h", pc, if_id_instr);

        // BR resolved under stall is ignored, then taken once stall drops
        stall = 1'b1; BranchTaken = 1'b1; is_br_instr = 1'b1; br_reg_data = 16'h0400;
        tick();
        chk("brstall_pc", pc, 16'h000E);
        chk("brstall_instr", if_id_instr, 16'h1006);
        chk("brstall_valid", 16'(if_id_valid), 16'h0001);
        $display("br under stall: pc=%h instr=%h", pc, if_id_instr);
        stall = 1'b0;
        tick();
        chk("br_pc", pc, 16'h0400);
        chk("br_bubble", 16'(if_id_valid), 16'h0000);
        $display("br redirect: pc=%h valid=%b", pc, if_id_valid);

        // HLT fetched at 0x0008
        br_reg_data = 16'h0008;
        tick();
        idle_inputs();
        tick();
        chk("hlt_halted", 16'(halted), 16'h0001);
        chk("hlt_pc", pc, 16'h0008);
        chk("hlt_instr", if_id_instr, 16'hF000);
        chk("hlt_valid", 16'(if_id_valid), 16'h0001);
        $display("hlt: halted=%b pc=%h instr=%h", halted, pc, if_id_instr);
        tick();
        chk("hlt_bubble", 16'(if_id_valid), 16'h0000);
        chk("hlt_hold_pc", pc, 16'h0008);
        $display("halted idle: pc=%h valid=%b", pc, if_id_valid);

        // Asynchronous reset between edges while halted
        #3 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 16'h0000);
        chk("arst_halted", 16'(halted), 16'h0000);
        chk("arst_valid", 16'(if_id_valid), 16'h0000);
        $display("async reset: pc=%h halted=%b", pc, halted);
        #1 rst = 1'b0;
        tick();
        chk("arst_first_fetch", if_id_instr, 16'h1234);

        // HLT on the wrong path of a taken B
        BranchTaken = 1'b1; is_br_instr = 1'b1; br_reg_data = 16'h0008;
        tick();
        is_br_instr = 1'b0; is_b_instr = 1'b1;
        id_pc_plus2 = 16'h0010; branch_imm9 = 9'h008;
        tick();
        chk("wp_halted", 16'(halted), 16'h0000);
        chk("wp_pc", pc, 16'h0020);
        chk("wp_valid", 16'(if_id_valid), 16'h0000);
        $display("wrong-path hlt: halted=%b pc=%h", halted, pc);
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 4) == 0);
            BranchTaken = ($urandom_range(0, 5) == 0);
            is_b_instr  = 1'($urandom);
            is_br_instr = 1'($urandom);
            branch_imm9 = 9'($urandom);
            id_pc_plus2 = 16'($urandom);
            br_reg_data = 16'($urandom);
            model_step();
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_valid", 16'(if_id_valid), 16'(m_valid));
            chk("rnd_instr", if_id_instr, m_instr);
            chk("rnd_halted", 16'(halted), 16'(m_halted));
            if (m_valid) chk("rnd_pc2", if_id_pc_plus2, m_pc2);
            if (c % 500 == 0)
                $display("rnd %0d: pc=%h instr=%h valid=%b halted=%b", c, pc, if_id_instr, if_id_valid, halted);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
